// File: rtl/clock_mon.sv
// clock_mon: measures high time, low time and period of an asynchronous
// clock-like signal in clk cycles, and flags a signal that stops toggling.
module clock_mon #(
   parameter int CNT_W       = 12,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             ovf,
   output logic             stuck,
   output logic             stuck_level
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic [CNT_W-1:0]       high_q, high_d, low_q, low_d, period_q, period_d;
   logic [TW-1:0]          idle_q, idle_d;
   logic                   meas_valid_q, meas_valid_d, ovf_q, ovf_d;
   logic                   stuck_q, stuck_d, stuck_level_q, stuck_level_d;
   logic                   s, rise, fall, timeout;
   logic [CNT_W:0]         sum;

   always_comb begin
      s             = sync_q[SYNC_STAGES-1];
      rise          = s & ~prev_q;
      fall          = ~s & prev_q;
      sum           = {1'b0, hcnt_q} + {1'b0, lcnt_q};
      // an edge in the threshold cycle restarts the idle count instead of timing out
      timeout       = !(rise || fall) && (idle_q >= TW'(TIMEOUT - 1));
      sync_d        = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d        = s;
      state_d       = state_q;
      hcnt_d        = hcnt_q;
      lcnt_d        = lcnt_q;
      idle_d        = (rise || fall) ? '0 : idle_q + 1'b1;
      high_d        = high_q;
      low_d         = low_q;
      period_d      = period_q;
      meas_valid_d  = 1'b0;
      ovf_d         = ovf_q;
      stuck_d       = stuck_q;
      stuck_level_d = stuck_level_q;
      if (!en) begin
         state_d = IDLE;
         hcnt_d  = '0;
         lcnt_d  = '0;
         idle_d  = '0;
         stuck_d = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = WAIT_RISE;
         hcnt_d  = '0;
         lcnt_d  = '0;
         idle_d  = '0;
      end else if (timeout) begin
         state_d       = WAIT_RISE;
         hcnt_d        = '0;
         lcnt_d        = '0;
         idle_d        = '0;
         stuck_d       = 1'b1;
         stuck_level_d = s;
      end else if (rise) begin
         state_d = MEAS_HIGH;
         hcnt_d  = CNT_W'(1);
         lcnt_d  = '0;
         if (state_q == MEAS_LOW) begin
            high_d       = hcnt_q;
            low_d        = lcnt_q;
            period_d     = sum[CNT_W] ? MAX : sum[CNT_W-1:0];
            ovf_d        = (hcnt_q == MAX) || (lcnt_q == MAX) || sum[CNT_W];
            meas_valid_d = 1'b1;
            stuck_d      = 1'b0;
         end
      end else if (fall) begin
         state_d = (state_q == MEAS_HIGH) ? MEAS_LOW : state_q;
         lcnt_d  = (state_q == MEAS_HIGH) ? CNT_W'(1) : lcnt_q;
      end else begin
         hcnt_d = (state_q == MEAS_HIGH && hcnt_q != MAX) ? hcnt_q + 1'b1 : hcnt_q;
         lcnt_d = (state_q == MEAS_LOW && lcnt_q != MAX) ? lcnt_q + 1'b1 : lcnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sync_q        <= '0;
         prev_q        <= 1'b0;
         hcnt_q        <= '0;
         lcnt_q        <= '0;
         idle_q        <= '0;
         high_q        <= '0;
         low_q         <= '0;
         period_q      <= '0;
         meas_valid_q  <= 1'b0;
         ovf_q         <= 1'b0;
         stuck_q       <= 1'b0;
         stuck_level_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync_q        <= sync_d;
         prev_q        <= prev_d;
         hcnt_q        <= hcnt_d;
         lcnt_q        <= lcnt_d;
         idle_q        <= idle_d;
         high_q        <= high_d;
         low_q         <= low_d;
         period_q      <= period_d;
         meas_valid_q  <= meas_valid_d;
         ovf_q         <= ovf_d;
         stuck_q       <= stuck_d;
         stuck_level_q <= stuck_level_d;
      end
   end

   assign high_cnt    = high_q;
   assign low_cnt     = low_q;
   assign period_cnt  = period_q;
   assign meas_valid  = meas_valid_q;
   assign ovf         = ovf_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuck_level_q;
endmodule

// File: tb/tb_clock_mon.sv
// tb_clock_mon: two clock_mon instances (12-bit/2-stage/TIMEOUT 16 and 4-bit/3-stage/TIMEOUT 64)
// checked every cycle against a run-length model, plus hand-computed publish values.
module tb_clock_mon;
   logic clk = 0, rst_n = 0, en = 0, sig_a = 0, sig_b = 0;
   logic [11:0] ha, la, pa;
   logic [3:0]  hb, lb, pb;
   logic        mva, ova, sta, sla, mvb, ovb, stb, slb;
   int checks = 0, errors = 0, cyc = 0;

   typedef struct {int hi; int lo; int pe; int ov; int t;} pub_t;
   pub_t pubs_a[$], pubs_b[$];

   int e_hi[2], e_lo[2], e_pe[2], e_mv[2], e_ov[2], e_st[2], e_sl[2];
   int ph[2], h[2], l[2], idl[2];
   bit hist[2][$];

   always #5 clk = ~clk;

   clock_mon #(.CNT_W(12), .SYNC_STAGES(2), .TIMEOUT(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_a),
      .high_cnt(ha), .low_cnt(la), .period_cnt(pa), .meas_valid(mva),
      .ovf(ova), .stuck(sta), .stuck_level(sla));

   clock_mon #(.CNT_W(4), .SYNC_STAGES(3), .TIMEOUT(64)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_b),
      .high_cnt(hb), .low_cnt(lb), .period_cnt(pb), .meas_valid(mvb),
      .ovf(ovb), .stuck(stb), .stuck_level(slb));

   function automatic int mx(input int k); return k ? 15 : 4095; endfunction
   function automatic int to(input int k); return k ? 64 : 16; endfunction
   function automatic int ss(input int k); return k ? 3 : 2; endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         ph[k] = 0; h[k] = 0; l[k] = 0; idl[k] = 0;
         e_hi[k] = 0; e_lo[k] = 0; e_pe[k] = 0; e_mv[k] = 0; e_ov[k] = 0; e_st[k] = 0; e_sl[k] = 0;
         hist[k].delete();
         repeat (ss(k) + 1) hist[k].push_front(1'b0);
      end
   endtask

   // ph: 0 disabled, 1 waiting for a rise, 2 in high phase, 3 in low phase; h/l are unclipped run lengths
   task automatic model_step(input int k, input bit in);
      bit s, p, rise, fall;
      s = hist[k][ss(k)-1];
      p = hist[k][ss(k)];
      rise = s && !p;
      fall = !s && p;
      e_mv[k] = 0;
      if (!en) begin
         ph[k] = 0; h[k] = 0; l[k] = 0; idl[k] = 0; e_st[k] = 0;
      end else if (ph[k] == 0) begin
         ph[k] = 1; h[k] = 0; l[k] = 0; idl[k] = 0;
      end else if (rise || fall) begin
         idl[k] = 0;
         if (rise) begin
            if (ph[k] == 3) begin
               e_hi[k] = h[k] > mx(k) ? mx(k) : h[k];
               e_lo[k] = l[k] > mx(k) ? mx(k) : l[k];
               e_pe[k] = h[k] + l[k] > mx(k) ? mx(k) : h[k] + l[k];
               e_ov[k] = (h[k] >= mx(k) || l[k] >= mx(k) || h[k] + l[k] > mx(k)) ? 1 : 0;
               e_mv[k] = 1;
               e_st[k] = 0;
            end
            ph[k] = 2; h[k] = 1; l[k] = 0;
         end else if (ph[k] == 2) begin
            ph[k] = 3; l[k] = 1;
         end
      end else if (idl[k] + 1 >= to(k)) begin
         e_st[k] = 1; e_sl[k] = s;
         ph[k] = 1; h[k] = 0; l[k] = 0; idl[k] = 0;
      end else begin
         idl[k]++;
         if (ph[k] == 2) h[k]++;
         if (ph[k] == 3) l[k]++;
      end
      hist[k].push_front(in);
      void'(hist[k].pop_back());
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_clear();
         else begin
            cyc++;
            model_step(0, sig_a);
            model_step(1, sig_b);
         end
      end
   end

   task automatic cmp(input string n, input int k, input int hi, input int lo, input int pe,
                      input int mv, input int ov, input int st, input int sl);
      chk({n, ".high_cnt"}, hi, e_hi[k]);
      chk({n, ".low_cnt"}, lo, e_lo[k]);
      chk({n, ".period_cnt"}, pe, e_pe[k]);
      chk({n, ".meas_valid"}, mv, e_mv[k]);
      chk({n, ".ovf"}, ov, e_ov[k]);
      chk({n, ".stuck"}, st, e_st[k]);
      chk({n, ".stuck_level"}, sl, e_sl[k]);
   endtask

   initial forever begin
      @(negedge clk);
      cmp("a", 0, ha, la, pa, mva, ova, sta, sla);
      cmp("b", 1, hb, lb, pb, mvb, ovb, stb, slb);
      if (mva) pubs_a.push_back('{ha, la, pa, ova, cyc});
      if (mvb) pubs_b.push_back('{hb, lb, pb, ovb, cyc});
   end

   task automatic drive(input int k, input bit v, input int n);
      if (k != 0) sig_b = v;
      else sig_a = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int k, input int hi, input int lo, input int n);
      repeat (n) begin
         drive(k, 1'b1, hi);
         drive(k, 1'b0, lo);
      end
   endtask

   task automatic chk_pub(input string n, input pub_t p, input int hi, input int lo, input int pe, input int ov);
      chk({n, ".high"}, p.hi, hi);
      chk({n, ".low"}, p.lo, lo);
      chk({n, ".period"}, p.pe, pe);
      chk({n, ".ovf"}, p.ov, ov);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      rst_n = 1;
      en = 1;
      drive(0, 0, 2);
      // steady 3/2 wave
      pubs_a.delete();
      wave(0, 3, 2, 6);
      drive(0, 0, 4);
      chk("p1.count", pubs_a.size(), 5);
      foreach (pubs_a[i]) begin
         chk_pub("p1", pubs_a[i], 3, 2, 5, 0);
         if (i > 0) chk("p1.spacing", pubs_a[i].t - pubs_a[i-1].t, 5);
      end
      // duty change 4/4 -> 6/2; entry 0 closes the previous run's stretched low
      pubs_a.delete();
      wave(0, 4, 4, 3);
      wave(0, 6, 2, 3);
      drive(0, 0, 4);
      chk("p2.count", pubs_a.size(), 6);
      if (pubs_a.size() == 6) begin
         for (int i = 1; i < 4; i++) chk_pub("p2.44", pubs_a[i], 4, 4, 8, 0);
         for (int i = 4; i < 6; i++) chk_pub("p2.62", pubs_a[i], 6, 2, 8, 0);
      end
      // stuck high
      sig_a = 1;
      k = 0;
      while (!sta && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("p3.stuck_delay", k, 19);
      chk("p3.stuck_level", sla, 1);
      wave(0, 3, 2, 3);
      drive(0, 0, 4);
      chk("p3.stuck_cleared", sta, 0);
      chk_pub("p3.restart", pubs_a[$], 3, 2, 5, 0);
      // en dropped for one cycle in the low phase
      wave(0, 3, 2, 2);
      drive(0, 1, 3);
      drive(0, 0, 2);
      pubs_a.delete();
      drive(0, 0, 2);
      en = 0;
      @(negedge clk);
      en = 1;
      chk("p4.hold_high", ha, 3);
      chk("p4.hold_low", la, 2);
      chk("p4.hold_period", pa, 5);
      chk("p4.no_valid", mva, 0);
      drive(0, 0, 2);
      wave(0, 3, 2, 4);
      drive(0, 0, 4);
      chk("p4.count", pubs_a.size(), 3);
      foreach (pubs_a[i]) chk_pub("p4", pubs_a[i], 3, 2, 5, 0);
      // both idle low long enough to time out, then saturation on the 4-bit instance
      repeat (70) @(negedge clk);
      chk("p5.a_stuck", sta, 1);
      chk("p5.a_level", sla, 0);
      chk("p5.b_stuck", stb, 1);
      chk("p5.b_level", slb, 0);
      pubs_b.delete();
      drive(1, 1, 20);
      drive(1, 0, 3);
      drive(1, 1, 2);
      drive(1, 0, 2);
      drive(1, 1, 2);
      drive(1, 0, 4);
      chk("p5.count", pubs_b.size(), 2);
      if (pubs_b.size() == 2) begin
         chk_pub("p5.sat", pubs_b[0], 15, 3, 15, 1);
         chk_pub("p5.norm", pubs_b[1], 2, 2, 4, 0);
      end
      chk("p5.b_stuck_cleared", stb, 0);
      // asynchronous reset mid-measurement
      wave(0, 3, 2, 2);
      sig_a = 1;
      @(posedge clk);
      #2 rst_n = 0;
      sig_a = 0;
      #1;
      chk("rst.a_high", ha, 0);
      chk("rst.a_low", la, 0);
      chk("rst.a_period", pa, 0);
      chk("rst.a_valid", mva, 0);
      chk("rst.a_ovf", ova, 0);
      chk("rst.b_high", hb, 0);
      chk("rst.b_low", lb, 0);
      chk("rst.b_period", pb, 0);
      chk("rst.b_stuck", stb, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      pubs_a.delete();
      drive(0, 0, 2);
      wave(0, 3, 2, 3);
      drive(0, 0, 4);
      chk("rst.count", pubs_a.size(), 2);
      foreach (pubs_a[i]) chk_pub("rst", pubs_a[i], 3, 2, 5, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
